// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - hazard, stall/flush and forwarding controller (option macro: FWD_COMPILE_EN)
module pipeline_hazard_unit #(
    parameter int NSTAGES = 3,
    parameter int FW_W    = $clog2(NSTAGES),
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           inst_i,
    input  logic                  inst_valid_i,
    input  logic                  redirect_i,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [FW_W-1:0]       rs1_fwd_o,
    output logic [FW_W-1:0]       rs2_fwd_o,
    output logic [32*NSTAGES-1:0] stage_inst_o,
    output logic [NSTAGES-1:0]    stage_valid_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REGREG = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    logic [31:0]        stage_inst [NSTAGES];
    logic [NSTAGES-1:0] stage_valid;
    logic               hazard;
    logic               accept;

    // Instruction produces a register result (x0 writes are discarded)
    function automatic logic writes(input logic [31:0] x);
        return (x[6:0] != OP_BRANCH) && (x[6:0] != OP_STORE) &&
               (x[6:0] != 7'd0) && (x[11:7] != 5'd0);
    endfunction

    function automatic logic reads_rs1(input logic [31:0] x);
        return (x[6:0] != OP_LUI) && (x[6:0] != OP_AUIPC) && (x[6:0] != OP_JAL) &&
               (x[6:0] != 7'd0) && (x[19:15] != 5'd0);
    endfunction

    function automatic logic reads_rs2(input logic [31:0] x);
        return ((x[6:0] == OP_REGREG) || (x[6:0] == OP_STORE) || (x[6:0] == OP_BRANCH)) &&
               (x[24:20] != 5'd0);
    endfunction

    // Producer's destination is one of the consumer's read sources
    function automatic logic feeds(input logic [31:0] prod, input logic [31:0] cons);
        return writes(prod) &&
               ((reads_rs1(cons) && (prod[11:7] == cons[19:15])) ||
                (reads_rs2(cons) && (prod[11:7] == cons[24:20])));
    endfunction

    // Detect a dependency that cannot be satisfied this cycle
    always_comb begin
        hazard = 1'b0;
`ifdef FWD_COMPILE_EN
        if (stage_valid[0] && (stage_inst[0][6:0] == OP_LOAD) && inst_valid_i &&
            feeds(stage_inst[0], inst_i))
            hazard = 1'b1;
`else
        for (int k = 0; k < NSTAGES; k++) begin
            if (stage_valid[k] && inst_valid_i && feeds(stage_inst[k], inst_i))
                hazard = 1'b1;
        end
`endif
    end

    // Redirect outranks stall; both are silenced while in reset
    assign stall_o = !rst && hazard && !redirect_i;
    assign flush_o = !rst && redirect_i;
    assign accept  = inst_valid_i && !stall_o && !redirect_i;

`ifdef FWD_COMPILE_EN
    // Pick the youngest producer: scan oldest to youngest so the smallest k overwrites
    always_comb begin
        rs1_fwd_o = '0;
        rs2_fwd_o = '0;
        if (!rst && stage_valid[0]) begin
            for (int k = NSTAGES - 1; k >= 1; k--) begin
                if (stage_valid[k] && writes(stage_inst[k])) begin
                    if (reads_rs1(stage_inst[0]) && (stage_inst[k][11:7] == stage_inst[0][19:15]))
                        rs1_fwd_o = FW_W'(k);
                    if (reads_rs2(stage_inst[0]) && (stage_inst[k][11:7] == stage_inst[0][24:20]))
                        rs2_fwd_o = FW_W'(k);
                end
            end
        end
    end
`else
    assign rs1_fwd_o = '0;
    assign rs2_fwd_o = '0;
`endif

    // Advance the stage shift register and the saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTAGES; k++) stage_inst[k] <= 32'h0;
            stage_valid <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            for (int k = 1; k < NSTAGES; k++) begin
                stage_inst[k]  <= stage_inst[k-1];
                stage_valid[k] <= stage_valid[k-1];
            end
            stage_inst[0]  <= accept ? inst_i : 32'h0;
            stage_valid[0] <= accept;
            if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush_o && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

    // Flatten the per-stage instruction words for the datapath control
    always_comb begin
        stage_inst_o = '0;
        for (int k = 0; k < NSTAGES; k++) stage_inst_o[32*k +: 32] = stage_inst[k];
    end

    assign stage_valid_o = stage_valid;

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

- Parametrised hazard and forwarding controller for the RISC-V core. It tracks the last NSTAGES instructions issued to execute, from execute to writeback.
- It issues operand-forwarding selects, load-use stalls and branch/jump flush bubbles.
- It sits between decode and the datapath control logic, which consumes the per-stage instruction words.
- Generalises the fixed three-register, two-source forwarding of the current design. Adds youngest-wins priority, x0 exclusion, stalling, flushing and event counters.

## Interface
- NSTAGES, 3: tracked stages. Stage 0 = execute, stage NSTAGES-1 = writeback. Legal range 2..8.
- FW_W, $clog2(NSTAGES): width of the forward selects.
- CNT_W, 16: width of the event counters.
- clk  in  1  main clock
- rst  in  1  reset; synchronous, active-high; single clock domain
- inst_i  in  32  instruction leaving decode
- inst_valid_i  in  1  inst_i is a real instruction
- redirect_i  in  1  taken branch/jump resolved in execute this cycle
- stall_o  out  1  hold fetch/decode; inst_i is not accepted
- flush_o  out  1  kill inst_i; fetch restarts at the target
- rs1_fwd_o  out  FW_W  0 = register file, k = result of stage k
- rs2_fwd_o  out  FW_W  same encoding, for rs2
- stage_inst_o  out  32*NSTAGES  stage k instruction at bits [32k+31:32k]
- stage_valid_o  out  NSTAGES  per-stage valid
- stall_cnt_o  out  CNT_W  saturating count of stall cycles
- flush_cnt_o  out  CNT_W  saturating count of flush cycles

## Operation
- **writes(x)**: opcode is not BRANCH (1100011), not STORE (0100011), not 0000000, and rd != 0.
- **reads_rs1(x)**: opcode is not LUI, AUIPC, JAL or 0000000, and rs1 != 0.
- **reads_rs2(x)**: opcode is REGREG, STORE or BRANCH, and rs2 != 0.
- A NOP is 32'h0 with valid 0.
- **Shift, every clock edge when not in reset:**
  - stage k <= stage k-1 for k = 1..NSTAGES-1.
  - stage 0 <= inst_i/valid only if inst_valid_i && !stall_o && !redirect_i; otherwise a NOP bubble.
- **Forwarding** (FWD_EN defined): for each source of stage 0 that is read, rsN_fwd_o = the smallest k ≥ 1 with valid(k) && writes(k) && rd(k) == rsN(0). If no stage matches, the select is 0. The youngest producer always wins.
- **Load-use hazard**: valid(0) && opcode(0) == LOAD && inst_valid_i && rd(0) matches a read source of inst_i.
- **stall_o** = hazard && !redirect_i.
- **flush_o** = redirect_i. Redirect has priority over stall; the stalled instruction is discarded.
- **Counters**:
  - stall_cnt_o increments on every cycle stall_o is high.
  - flush_cnt_o increments on every cycle flush_o is high.
  - Both saturate at all-ones and never wrap.
- **Reset**: all stages NOP, stage_valid_o = 0, counters = 0. Applies even mid-stall or mid-flush; the next cycle accepts inst_i normally.

## Timing
- stall_o, flush_o, rs1_fwd_o and rs2_fwd_o are combinational from inst_i, redirect_i and the stage registers. No registered outputs on these paths.
- An instruction accepted at edge n is in stage k during cycle n+k. It leaves the unit after stage NSTAGES-1.
- A load-use stall lasts exactly one cycle. The consumer enters stage 0 one edge late, with the load in stage 2 and forwarded with select 2.
- Flush inserts exactly one bubble into stage 0. Older stages continue shifting.
- Simultaneous stall hazard and redirect: flush_o = 1, stall_o = 0, stall_cnt_o unchanged.
- Output values during reset:
  - stall_o = 0 and flush_o = 0 are forced while rst is high.
  - Forward selects are 0 (stages empty).

## Configuration
- **FWD_COMPILE_EN** defined: forwarding as above; only load-use hazards stall.
- **FWD_COMPILE_EN** undefined:
  - rs1_fwd_o and rs2_fwd_o are tied to 0.
  - The hazard becomes: any valid(k) && writes(k) && rd(k) matches a read source of inst_i, for k = 0..NSTAGES-1.
  - stall_o holds until no such producer remains, up to NSTAGES cycles.

## Test plan
- **Youngest-wins forwarding**: addi x5,x0,1; addi x5,x5,2; add x6,x5,x5 (FWD_EN, NSTAGES=3) -> add in stage 0 shows rs1_fwd_o = rs2_fwd_o = 1, not 2.
- **x0 exclusion**: addi x0,x0,7; add x1,x0,x0 -> both selects 0, stall_o never asserted.
- **Load-use stall**: lw x3,0(x1) then add x4,x3,x2:
  - stall_o = 1 for exactly one cycle, and stage 0 holds a bubble.
  - Next cycle add is in stage 0 with rs1_fwd_o = 2.
  - stall_cnt_o = 1.
- **Redirect during stall**: lw x3 then dependent add, with redirect_i = 1 in the hazard cycle -> flush_o = 1, stall_o = 0, add never enters stage 0, flush_cnt_o = 1, stall_cnt_o = 0.
- **No-forward build and counters**:
  - FWD_COMPILE_EN undefined, NSTAGES=3: addi x5 then add x6,x5,x0 -> stall_o high 3 cycles, add enters after the addi leaves writeback.
  - CNT_W=2: 5 stall cycles -> stall_cnt_o = 3.
- **Reset mid-stall**: assert rst during the stall cycle -> all stage_valid_o = 0, counters 0, stall_o = 0. The next valid inst_i is accepted into stage 0.
